// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Walks the built-in four-input gate block through all 16 input combinations.
// Each combination is held for SETTLE+1 cycles and then sampled. Every
// captured 10-bit output vector is streamed out and folded into a 16-bit MISR
// so that a single signature compare gives a pass/fail verdict.
//
// Ports
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   start_i         sweep request, only honoured while idle
//   abort_i         ends a running sweep, wins over start_i
//   gate_o_i[9:0]   gate block outputs, bit0 = o1 ... bit9 = o10
//   gate_a_o..d_o   registered drives onto gate block inputs a,b,c,d
//   busy_o          high whenever a sweep is in progress
//   vec_idx_o[3:0]  index of the vector currently driven (0 when idle)
//   sample_valid_o  one-cycle pulse qualifying sample_data_o/sample_idx_o
//   sample_data_o   captured gate outputs
//   sample_idx_o    vector index belonging to sample_data_o
//   done_o          one-cycle pulse on normal completion
//   signature_o     MISR value, meaningful while sig_valid_o is high
//   sig_valid_o     high from done_o until the next accepted start/abort/reset
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [9:0]  gate_o_i,
  output logic        gate_a_o,
  output logic        gate_b_o,
  output logic        gate_c_o,
  output logic        gate_d_o,
  output logic        busy_o,
  output logic [3:0]  vec_idx_o,
  output logic        sample_valid_o,
  output logic [9:0]  sample_data_o,
  output logic [3:0]  sample_idx_o,
  output logic        done_o,
  output logic [15:0] signature_o,
  output logic        sig_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_e;

  localparam logic [3:0]  SettleLoad = 4'(SETTLE);
  localparam logic [15:0] SigSeed    = 16'hFFFF;
  // With no settle time every window is a single SAMPLE cycle.
  localparam state_e      WindowStart = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        sample_valid_q, sample_valid_d;
  logic [9:0]  sample_data_q, sample_data_d;
  logic [3:0]  sample_idx_q, sample_idx_d;
  logic        done_q, done_d;
  logic [15:0] sig_q, sig_d;
  logic        sig_valid_q, sig_valid_d;

  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [9:0]  data);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ {6'b0, data};
  endfunction

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    sample_idx_d   = sample_idx_q;
    done_d         = 1'b0;
    sig_d          = sig_q;
    sig_valid_d    = sig_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          idx_d       = 4'd0;
          sig_d       = SigSeed;
          sig_valid_d = 1'b0;
          cnt_d       = SettleLoad;
          state_d     = WindowStart;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_valid_d = 1'b1;
        sample_data_d  = gate_o_i;
        sample_idx_d   = idx_q;
        sig_d          = misr_next(sig_q, gate_o_i);
        if (idx_q == 4'd15) begin
          // Drives drop to zero on entry to FINISH, so vec_idx reads 0 there.
          idx_d       = 4'd0;
          done_d      = 1'b1;
          sig_valid_d = 1'b1;
          state_d     = ST_FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = SettleLoad;
          state_d = WindowStart;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort cancels whatever the current state was about to register,
    // including a capture in a SAMPLE cycle.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d        = ST_IDLE;
      idx_d          = 4'd0;
      sample_valid_d = 1'b0;
      sample_data_d  = sample_data_q;
      sample_idx_d   = sample_idx_q;
      sig_d          = sig_q;
      done_d         = 1'b0;
      sig_valid_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= 4'd0;
      cnt_q          <= 4'd0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 10'd0;
      sample_idx_q   <= 4'd0;
      done_q         <= 1'b0;
      sig_q          <= SigSeed;
      sig_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      sample_idx_q   <= sample_idx_d;
      done_q         <= done_d;
      sig_q          <= sig_d;
      sig_valid_q    <= sig_valid_d;
    end
  end

  // idx_q is held at zero outside SETTLE/SAMPLE, so it doubles as the drive register.
  assign gate_a_o       = idx_q[3];
  assign gate_b_o       = idx_q[2];
  assign gate_c_o       = idx_q[1];
  assign gate_d_o       = idx_q[0];
  assign vec_idx_o      = idx_q;
  assign busy_o         = busy_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_data_o  = sample_data_q;
  assign sample_idx_o   = sample_idx_q;
  assign done_o         = done_q;
  assign signature_o    = sig_q;
  assign sig_valid_o    = sig_valid_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl
// Bench for gate_sweep_ctrl. Two instances share clock and reset: one with
// SETTLE=2 driving a behavioural gate block model, one with SETTLE=0 whose
// gate outputs are tied to zero. Each sweep is recorded cycle by cycle into
// log arrays and then compared against a timing table and a MISR model.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start2, abort2, start0, abort0;

  logic [9:0]  gateOut2, gateOut0;
  logic        gateA2, gateB2, gateC2, gateD2, busy2, sv2, done2, sigv2;
  logic [3:0]  vidx2, sidx2;
  logic [9:0]  sdata2;
  logic [15:0] sig2;
  logic        gateA0, gateB0, gateC0, gateD0, busy0, sv0, done0, sigv0;
  logic [3:0]  vidx0, sidx0;
  logic [9:0]  sdata0;
  logic [15:0] sig0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [3:0] vidx;
    logic       sv;
    logic       done;
    logic       sigv;
  } vecRec_t;

  vecRec_t timingTable[14];

  logic        busyLog[128];
  logic [3:0]  vidxLog[128];
  logic [3:0]  drvLog[128];
  logic        svLog[128];
  logic [3:0]  sidxLog[128];
  logic [9:0]  sdataLog[128];
  logic        doneLog[128];
  logic        sigvLog[128];
  logic [15:0] sigLog[128];

  logic [15:0] expSig, zeroSig;

  always #5 clk = ~clk;

  // Behavioural gate block: o1 = and4, o2 = nand4, o3 = or4, o4 = nor4,
  // o5 = xor4, o6 = xnor4, o7 = ab|cd, o8 = (a|b)(c|d), o9 = a^b, o10 = c xnor d.
  function automatic logic [9:0] gateModel(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return {c ~^ d, a ^ b, (a | b) & (c | d), (a & b) | (c & d),
            ~(a ^ b ^ c ^ d), a ^ b ^ c ^ d, ~(a | b | c | d), a | b | c | d,
            ~(a & b & c & d), a & b & c & d};
  endfunction

  function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] shifted;
    shifted = {s[14:0], 1'b0};
    if (s[15]) shifted = shifted ^ 16'h1021;
    return shifted ^ {6'b000000, d};
  endfunction

  assign gateOut2 = gateModel({gateA2, gateB2, gateC2, gateD2});
  assign gateOut0 = 10'h000;

  gate_sweep_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
    .gate_o_i(gateOut2),
    .gate_a_o(gateA2), .gate_b_o(gateB2), .gate_c_o(gateC2), .gate_d_o(gateD2),
    .busy_o(busy2), .vec_idx_o(vidx2), .sample_valid_o(sv2),
    .sample_data_o(sdata2), .sample_idx_o(sidx2), .done_o(done2),
    .signature_o(sig2), .sig_valid_o(sigv2)
  );

  gate_sweep_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0),
    .gate_o_i(gateOut0),
    .gate_a_o(gateA0), .gate_b_o(gateB0), .gate_c_o(gateC0), .gate_d_o(gateD0),
    .busy_o(busy0), .vec_idx_o(vidx0), .sample_valid_o(sv0),
    .sample_data_o(sdata0), .sample_idx_o(sidx0), .done_o(done0),
    .signature_o(sig0), .sig_valid_o(sigv0)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic logCycle(input int c, input bit zeroDut);
    if (zeroDut) begin
      busyLog[c] = busy0; vidxLog[c] = vidx0; drvLog[c] = {gateA0, gateB0, gateC0, gateD0};
      svLog[c] = sv0; sidxLog[c] = sidx0; sdataLog[c] = sdata0;
      doneLog[c] = done0; sigvLog[c] = sigv0; sigLog[c] = sig0;
    end else begin
      busyLog[c] = busy2; vidxLog[c] = vidx2; drvLog[c] = {gateA2, gateB2, gateC2, gateD2};
      svLog[c] = sv2; sidxLog[c] = sidx2; sdataLog[c] = sdata2;
      doneLog[c] = done2; sigvLog[c] = sigv2; sigLog[c] = sig2;
    end
  endtask

  // Cycle c is observed at its falling edge, then the inputs for cycle c are
  // driven; they are sampled by the rising edge that ends cycle c.
  task automatic applyStimulus(input bit zeroDut, input int nCycles, input int startHold,
                               input int abortAt, input int pulseAt);
    logic st, ab;
    @(negedge clk);
    for (int c = 0; c < nCycles; c++) begin
      if (c > 0) @(negedge clk);
      logCycle(c, zeroDut);
      st = (c < startHold) || (c == pulseAt);
      ab = (c == abortAt);
      if (zeroDut) begin start0 = st; abort0 = ab; end
      else begin start2 = st; abort2 = ab; end
    end
    start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
  endtask

  // Full SETTLE=2 sweep whose start was sampled in log cycle 'base'.
  task automatic checkSweep2(input int base, input bit useTable, input logic [15:0] sigExp);
    int n, doneCnt, firstDone, busyCnt;
    n = 0; doneCnt = 0; firstDone = -1; busyCnt = 0;
    for (int c = base + 1; c <= base + 50; c++) begin
      if (busyLog[c]) busyCnt++;
      if (svLog[c]) begin
        checkOutput("sampleCycle", c, base + 4 + 3 * n);
        checkOutput("sampleIdx", {28'd0, sidxLog[c]}, n);
        checkOutput("sampleData", {22'd0, sdataLog[c]}, {22'd0, gateModel(4'(n))});
        n++;
      end
      if (doneLog[c]) begin
        doneCnt++;
        if (firstDone < 0) firstDone = c;
      end
      if (c <= base + 48) begin
        checkOutput("vecIdx", {28'd0, vidxLog[c]}, (c - base - 1) / 3);
        checkOutput("driveAbcd", {28'd0, drvLog[c]}, (c - base - 1) / 3);
      end
    end
    checkOutput("sampleCount", n, 16);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("doneCycle", firstDone, base + 49);
    checkOutput("busyLength", busyCnt, 49);
    checkOutput("busyFall", {31'd0, busyLog[base + 50]}, 0);
    checkOutput("signature", {16'd0, sigLog[base + 49]}, {16'd0, sigExp});
    checkOutput("sigValidAtDone", {31'd0, sigvLog[base + 49]}, 1);
    if (useTable) begin
      for (int i = 0; i < 14; i++) begin
        int c;
        c = base + timingTable[i].cyc;
        checkOutput($sformatf("tblBusy@%0d", timingTable[i].cyc), {31'd0, busyLog[c]}, {31'd0, timingTable[i].busy});
        checkOutput($sformatf("tblVidx@%0d", timingTable[i].cyc), {28'd0, vidxLog[c]}, {28'd0, timingTable[i].vidx});
        checkOutput($sformatf("tblValid@%0d", timingTable[i].cyc), {31'd0, svLog[c]}, {31'd0, timingTable[i].sv});
        checkOutput($sformatf("tblDone@%0d", timingTable[i].cyc), {31'd0, doneLog[c]}, {31'd0, timingTable[i].done});
        checkOutput($sformatf("tblSigValid@%0d", timingTable[i].cyc), {31'd0, sigvLog[c]}, {31'd0, timingTable[i].sigv});
      end
    end
  endtask

  initial begin
    int n, cnt, maxIdx;

    // Hand-derived SETTLE=2 timeline: vector k is driven in cycles 3k+1..3k+3,
    // its sample pulse lands in cycle 3k+4, done in cycle 49.
    timingTable[0]  = '{0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
    timingTable[1]  = '{1,  1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
    timingTable[2]  = '{3,  1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
    timingTable[3]  = '{4,  1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
    timingTable[4]  = '{5,  1'b1, 4'd1,  1'b0, 1'b0, 1'b0};
    timingTable[5]  = '{7,  1'b1, 4'd2,  1'b1, 1'b0, 1'b0};
    timingTable[6]  = '{16, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0};
    timingTable[7]  = '{21, 1'b1, 4'd6,  1'b0, 1'b0, 1'b0};
    timingTable[8]  = '{22, 1'b1, 4'd7,  1'b1, 1'b0, 1'b0};
    timingTable[9]  = '{46, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
    timingTable[10] = '{48, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
    timingTable[11] = '{49, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1};
    timingTable[12] = '{50, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
    timingTable[13] = '{53, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};

    expSig = 16'hFFFF;
    for (int i = 0; i < 16; i++) expSig = misrStep(expSig, gateModel(4'(i)));
    zeroSig = 16'hFFFF;
    for (int i = 0; i < 16; i++) zeroSig = misrStep(zeroSig, 10'h000);

    rst_n = 1'b0; start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy2}, 0);
    checkOutput("rstSig", {16'd0, sig2}, 32'hFFFF);
    checkOutput("rstSigValid", {31'd0, sigv2}, 0);
    checkOutput("rstDrive", {28'd0, gateA2, gateB2, gateC2, gateD2}, 0);
    checkOutput("rstSigZeroDut", {16'd0, sig0}, 32'hFFFF);
    rst_n = 1'b1;

    $display("[TB] SETTLE=2 sweep with a stray start pulse mid-sweep");
    applyStimulus(0, 56, 1, -1, 20);
    checkSweep2(0, 1, expSig);
    for (int c = 50; c < 56; c++) checkOutput("sigStable", {16'd0, sigLog[c]}, {16'd0, expSig});

    $display("[TB] SETTLE=0 sweep with gate outputs tied low");
    applyStimulus(1, 24, 1, -1, -1);
    n = 0; cnt = 0;
    for (int c = 1; c < 24; c++) begin
      if (busyLog[c]) cnt++;
      if (c <= 16) checkOutput("zVecIdx", {28'd0, vidxLog[c]}, c - 1);
      if (svLog[c]) begin
        checkOutput("zSampleCycle", c, n + 2);
        checkOutput("zSampleIdx", {28'd0, sidxLog[c]}, n);
        checkOutput("zSampleData", {22'd0, sdataLog[c]}, 0);
        n++;
      end
      if (c >= 17) checkOutput("zSigStable", {16'd0, sigLog[c]}, {16'd0, zeroSig});
    end
    checkOutput("zBusyLength", cnt, 17);
    checkOutput("zSampleCount", n, 16);
    checkOutput("zDone", {31'd0, doneLog[17]}, 1);
    checkOutput("zBusyFall", {31'd0, busyLog[18]}, 0);
    checkOutput("zSigValid", {31'd0, sigvLog[17]}, 1);

    $display("[TB] start and abort together while idle");
    @(negedge clk);
    start2 = 1'b1; abort2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bothBusy", {31'd0, busy2}, 0);
      checkOutput("bothVidx", {28'd0, vidx2}, 0);
      checkOutput("bothSigValid", {31'd0, sigv2}, 1);
      checkOutput("bothSig", {16'd0, sig2}, {16'd0, expSig});
    end
    start2 = 1'b0; abort2 = 1'b0;

    $display("[TB] abort while vector 5 is driven");
    applyStimulus(0, 40, 1, 16, -1);
    checkOutput("abortVecAtAbort", {28'd0, vidxLog[16]}, 5);
    checkOutput("abortLastPulse", {31'd0, svLog[16]}, 1);
    checkOutput("abortLastIdx", {28'd0, sidxLog[16]}, 4);
    checkOutput("abortBusy", {31'd0, busyLog[17]}, 0);
    checkOutput("abortDrive", {28'd0, drvLog[17]}, 0);
    checkOutput("abortVidx", {28'd0, vidxLog[17]}, 0);
    n = 0; cnt = 0; maxIdx = 0;
    for (int c = 1; c < 40; c++) begin
      if (doneLog[c] || sigvLog[c]) cnt++;
      if (svLog[c]) begin
        n++;
        if (int'(sidxLog[c]) > maxIdx) maxIdx = int'(sidxLog[c]);
      end
    end
    checkOutput("abortNoDoneNoSigValid", cnt, 0);
    checkOutput("abortSampleCount", n, 5);
    checkOutput("abortMaxIdx", maxIdx, 4);

    $display("[TB] asynchronous reset in the middle of a settle window");
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preRstBusy", {31'd0, busy2}, 1);
    checkOutput("preRstVidx", {28'd0, vidx2}, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", {31'd0, busy2}, 0);
    checkOutput("asyncDrive", {28'd0, gateA2, gateB2, gateC2, gateD2}, 0);
    checkOutput("asyncVidx", {28'd0, vidx2}, 0);
    checkOutput("asyncValid", {31'd0, sv2}, 0);
    checkOutput("asyncData", {22'd0, sdata2}, 0);
    checkOutput("asyncSidx", {28'd0, sidx2}, 0);
    checkOutput("asyncDone", {31'd0, done2}, 0);
    checkOutput("asyncSig", {16'd0, sig2}, 32'hFFFF);
    checkOutput("asyncSigValid", {31'd0, sigv2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 56, 1, -1, -1);
    checkSweep2(0, 1, expSig);

    $display("[TB] back-to-back sweeps with start held across FINISH");
    applyStimulus(0, 105, 52, -1, -1);
    checkSweep2(0, 0, expSig);
    checkOutput("b2bIdleGap", {31'd0, busyLog[50]}, 0);
    checkOutput("b2bSigValidGap", {31'd0, sigvLog[50]}, 1);
    checkOutput("b2bBusyAgain", {31'd0, busyLog[51]}, 1);
    checkOutput("b2bSigValidDrop", {31'd0, sigvLog[51]}, 0);
    checkOutput("b2bReseed", {16'd0, sigLog[51]}, 32'hFFFF);
    checkSweep2(50, 0, expSig);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises the four-input built-in gate block: it drives all 16 combinations of `a,b,c,d` onto the gate block, waits a programmable settle time, and captures the 10-bit gate output vector `o1..o10` for each combination. Every captured vector is streamed out and folded into a 16-bit signature (MISR), so one compare gives on-chip pass/fail. It sits between the gate block and the team's test/status logic, replacing hand-written stimulus with a clocked, repeatable sweep.

## Interface
- `SETTLE`, default 2: idle cycles a vector is held before sampling. Range 0..15; the window per vector is SETTLE+1 cycles.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  terminates a sweep; has priority over `start`.
- `gate_o`  in  10  gate block outputs; bit0=`o1` … bit9=`o10`.
- `gate_a`, `gate_b`, `gate_c`, `gate_d`  out  1 each  registered drives to gate block inputs `a,b,c,d`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `vec_idx`  out  4  index of the vector currently driven.
- `sample_valid`  out  1  one-cycle pulse; `sample_data` is valid.
- `sample_data`  out  10  captured `gate_o` for index `sample_idx`.
- `sample_idx`  out  4  vector index belonging to `sample_data`.
- `done`  out  1  one-cycle pulse on normal completion.
- `signature`  out  16  MISR value; meaningful when `sig_valid`=1.
- `sig_valid`  out  1  high from `done` until the next accepted `start`, `abort` or reset.

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- Vector mapping: `gate_a`=idx[3], `gate_b`=idx[2], `gate_c`=idx[1], `gate_d`=idx[0].
- IDLE: gate drives are 0. When `start`=1 and `abort`=0: idx←0, signature←16'hFFFF, sig_valid←0, settle counter←SETTLE, go to SETTLE (or directly to SAMPLE if SETTLE=0).
- SETTLE: the counter decrements each cycle. When it reaches 1, the next state is SAMPLE.
- SAMPLE (1 cycle): capture `gate_o` into `sample_data` and `sample_idx`←idx. Update the signature: sig←({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0)) ^ {6'b0, gate_o}.
  - If idx=15: go to FINISH.
  - Otherwise: idx←idx+1, reload the counter, go to SETTLE (or stay in SAMPLE if SETTLE=0).
- FINISH (1 cycle): `done`=1, `sig_valid`←1, gate drives←0, then go to IDLE.
- `abort`=1 in any non-IDLE state: next state is IDLE, gate drives←0, no `done`, `sig_valid` stays 0, no further `sample_valid`. A pulse already registered from the preceding SAMPLE still appears.
- `start` while busy is ignored. `start` held high in IDLE after FINISH begins a new sweep.
- Reset (asynchronous, any time): state IDLE, idx 0, all gate drives 0, `busy`/`done`/`sample_valid`/`sig_valid` 0, `sample_data` 0, `sample_idx` 0, `signature` 16'hFFFF.
- `vec_idx` is 0 outside active states.

## Timing
- `start` sampled in cycle 0:
  - `busy`=1 and vector 0 driven from cycle 1.
  - Vector k is driven during cycles 1+k·(SETTLE+1) through (k+1)·(SETTLE+1).
  - SAMPLE is the last cycle of each window.
- `sample_valid` and `sample_data` appear the cycle after the SAMPLE cycle. The next vector is already driven in that cycle.
- FINISH (the `done` pulse) is cycle 16·(SETTLE+1)+1, the same cycle as the final `sample_valid`. `busy` falls the cycle after.
- Total busy length is 16·(SETTLE+1)+1 cycles; 49 for SETTLE=2, 17 for SETTLE=0.
- The gate block is combinational; SETTLE covers the drive-register → gate → capture path. No handshake on `gate_o`.

## Test plan
- SETTLE=2, gate model connected, `start` pulsed at cycle 0:
  - `busy` rises in cycle 1 and `done` pulses in cycle 49.
  - 16 `sample_valid` pulses occur with `sample_idx` 0..15 in order.
  - Each `sample_data` equals the model output for that index.
  - `signature` matches the bench MISR model.
- `gate_o` forced to 10'h000, SETTLE=0: the sweep completes in 17 busy cycles. `signature` equals the bench model of 16 zero-data shifts from 16'hFFFF, and is stable while `sig_valid`=1.
- `abort` asserted in the cycle vector 5 is driven:
  - IDLE next cycle, all gate drives 0.
  - No `done`, `sig_valid`=0, no `sample_idx` ≥ 6.
- `start` and `abort` both high in IDLE: no state change, `busy` stays 0. `start` pulsed mid-sweep: the sweep timing is unchanged.
- `rst_n` dropped asynchronously mid-SETTLE (between clock edges): all outputs take reset values immediately. After release, `start` runs a full, correct sweep.
- Back-to-back: `start` held high across FINISH. A second sweep begins the cycle after FINISH, with `sig_valid` dropping and the signature reseeded to 16'hFFFF.
